// File: rtl/iobuf_ctrl.sv
// Per-pin iobuf sequencer: enforces oe dead-time around dir/od changes, syncs dout for read-back.
// Commands are accepted only in IDLE; all pin and response outputs are registered.
module iobuf_ctrl #(
  parameter int TURN_CYCLES   = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_data,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       busy,
  output logic       oe,
  output logic       od,
  output logic       dir,
  output logic       din,
  input  logic       dout
);

  localparam int TURN_LOAD_I = TURN_CYCLES - 1;
  localparam int WAIT_LOAD_I = SETTLE_CYCLES + SYNC_STAGES - 1;
  localparam int CNT_MAX     = (TURN_LOAD_I > WAIT_LOAD_I) ? TURN_LOAD_I : WAIT_LOAD_I;
  localparam int CW          = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_LOAD_I);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_LOAD_I);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_HIZ    = 3'd1;
  localparam logic [2:0] OP_SET_PP = 3'd2;
  localparam logic [2:0] OP_SET_OD = 3'd3;
  localparam logic [2:0] OP_INPUT  = 3'd4;
  localparam logic [2:0] OP_READ   = 3'd5;
  localparam logic [2:0] OP_WR     = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TURN   = 2'd1,
    S_ENABLE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            tgt_dir, tgt_od, tgt_din;
  logic            tgt_dir_nxt, tgt_od_nxt, tgt_din_nxt;
  logic            oe_nxt, od_nxt, dir_nxt, din_nxt;
  logic            rsp_valid_nxt, rsp_data_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            dout_sync;

  logic            accept;
  logic            is_cfg, is_rd;
  logic            op_dir, op_od;
  logic            same_cfg;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign dout_sync = sync_q[SYNC_STAGES-1];

  // Decode the configuration a SET/INPUT command is asking for.
  always_comb begin
    is_cfg = 1'b0;
    is_rd  = 1'b0;
    op_dir = dir;
    op_od  = od;
    case (cmd_op)
      OP_SET_PP: begin is_cfg = 1'b1; op_dir = 1'b0; op_od = 1'b0; end
      OP_SET_OD: begin is_cfg = 1'b1; op_dir = 1'b0; op_od = 1'b1; end
      OP_INPUT:  begin is_cfg = 1'b1; op_dir = 1'b1; op_od = 1'b0; end
      OP_READ, OP_WR: is_rd = 1'b1;
      default: ;
    endcase
  end

  assign same_cfg = (op_dir == dir) && (op_od == od);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_cfg) begin
            if (!oe)           state_nxt = S_ENABLE;
            else if (!same_cfg) state_nxt = S_TURN;
          end else if (is_rd) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_TURN:   if (cnt == '0) state_nxt = S_ENABLE;
      S_ENABLE: state_nxt = S_IDLE;
      S_WAIT:   if (cnt == '0) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oe_nxt        = oe;
    od_nxt        = od;
    dir_nxt       = dir;
    din_nxt       = din;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = rsp_data;
    cnt_nxt       = cnt;
    tgt_dir_nxt   = tgt_dir;
    tgt_od_nxt    = tgt_od;
    tgt_din_nxt   = tgt_din;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_HIZ) begin
            oe_nxt = 1'b0;
          end else if (is_cfg) begin
            tgt_dir_nxt = op_dir;
            tgt_od_nxt  = op_od;
            tgt_din_nxt = cmd_data;
            if (!oe) begin
              // Buffer already disabled: dir/od can move now, oe follows next cycle.
              dir_nxt = op_dir;
              od_nxt  = op_od;
              din_nxt = cmd_data;
            end else if (same_cfg) begin
              din_nxt = cmd_data;
            end else begin
              oe_nxt  = 1'b0;
              cnt_nxt = TURN_LOAD;
            end
          end else if (is_rd) begin
            if (cmd_op == OP_WR) din_nxt = cmd_data;
            cnt_nxt = WAIT_LOAD;
          end
        end
      end
      S_TURN: begin
        if (cnt == '0) begin
          dir_nxt = tgt_dir;
          od_nxt  = tgt_od;
          din_nxt = tgt_din;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_ENABLE: oe_nxt = 1'b1;
      S_WAIT: begin
        if (cnt == '0) begin
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = dout_sync;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe        <= 1'b0;
      od        <= 1'b0;
      dir       <= 1'b1;
      din       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      cnt       <= '0;
      tgt_dir   <= 1'b1;
      tgt_od    <= 1'b0;
      tgt_din   <= 1'b0;
    end else begin
      oe        <= oe_nxt;
      od        <= od_nxt;
      dir       <= dir_nxt;
      din       <= din_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      cnt       <= cnt_nxt;
      tgt_dir   <= tgt_dir_nxt;
      tgt_od    <= tgt_od_nxt;
      tgt_din   <= tgt_din_nxt;
    end
  end

  // dout is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], dout};
  end

endmodule
